rv32i_fetch_unit: RTL

- Instruction fetch stage directly upstream of the main control decoder in the rv32i core.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request and valid-only response interface.
- Buffers returned instructions in a small in-order queue and presents them, with their PC, to decode via a valid/ready handshake.
- Accepts redirects (taken branch, jal, jalr) that flush buffered and in-flight instructions and restart fetch at a new PC.

---
 rtl/rv32i_fetch_unit.sv | 106 ++++++++++
 1 files changed

// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned imem requests under a credit
// limit, buffers in-order responses and hands them to decode; redirects flush everything.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] pcq_rd;
  logic [PW-1:0] pcq_wr;
  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   pcq      [DEPTH];

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          pop;
  logic [CW:0]   in_use;
  logic [CW-1:0] outstanding_nxt;
  logic          redirect_lsb_unused;

  assign in_use          = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok       = in_use < DEPTH_W;
  assign imem_req_valid  = ~rst & ~redirect_valid & credit_ok;
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid & imem_req_ready;
  // a beat arriving during a redirect belongs to the old stream
  assign rsp_drop        = imem_rsp_valid & ((drop != '0) | redirect_valid);
  assign rsp_keep        = imem_rsp_valid & ~rsp_drop;
  assign inst_valid      = ~rst & (count != '0);
  assign pop             = inst_valid & inst_ready;
  assign inst            = buf_inst[rd_ptr];
  assign inst_pc         = buf_pc[rd_ptr];
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      // the in-flight PC queue tracks every beat, stale or not, so it never needs flushing
      if (req_fire)       pcq_wr <= ptr_inc(pcq_wr);
      if (imem_rsp_valid) pcq_rd <= ptr_inc(pcq_rd);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        drop     <= outstanding_nxt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop) drop     <= drop - CW'(1);
        if (rsp_keep) wr_ptr   <= ptr_inc(wr_ptr);
        if (pop)      rd_ptr   <= ptr_inc(rd_ptr);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= fetch_pc;
    if (rsp_keep) begin
      buf_inst[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr]   <= pcq[pcq_rd];
    end
  end

endmodule
